axis_packet_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that merges NUM_SRC AXI-Stream sources onto one AXI-Stream master.
- Typically drives the slave side of axi_stream_fifo.
- A grant is held for a whole packet, from the first accepted beat through the beat carrying tlast, so packets are never interleaved.
- Fairness is round-robin starting after the last granted source.

---
 rtl/axis_arb_pkg.sv | 11 +
 rtl/rr_picker.sv | 34 +++
 rtl/axis_packet_arbiter.sv | 93 +++++++++
 tb/tb_axis_packet_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and limits for the AXI-Stream packet arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_PKT  = 1'b1
    } arb_state_e;

    localparam int MAX_SRC = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping modulo NUM_SRC.
module rr_picker #(
    parameter  int NUM_SRC = 4,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic               any_req,
    output logic [SRC_W-1:0]   winner
);

    logic [SRC_W:0]     start;
    logic [SRC_W:0]     sum;
    logic [NUM_SRC-1:0] rot;
    logic [SRC_W-1:0]   offset;

    // Rotate so the highest-priority source lands at bit 0, encode, then rotate back.
    always_comb begin
        start  = (SRC_W+1)'(last) + (SRC_W+1)'(1);
        rot    = NUM_SRC'({req, req} >> start);
        offset = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offset = SRC_W'(i);
            end
        end
        sum    = start + (SRC_W+1)'(offset);
        winner = (sum >= (SRC_W+1)'(NUM_SRC)) ? SRC_W'(sum - (SRC_W+1)'(NUM_SRC))
                                              : SRC_W'(sum);
    end

    assign any_req = |req;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-aware round-robin AXI-Stream merger; grant held from first beat through tlast.
// Optional AXIS_ARB_TID_EN adds m_axis_tid carrying the granted source index.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC    = 4,
    parameter  int DATA_WIDTH = 32,
    localparam int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_tvalid,
    output logic [NUM_SRC-1:0]            s_axis_tready,
    input  logic [NUM_SRC-1:0]            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [SRC_W-1:0]              grant_idx,
    output logic                          busy
`ifdef AXIS_ARB_TID_EN
    ,
    output logic [SRC_W-1:0]              m_axis_tid
`endif
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [SRC_W-1:0] last_grant;
    logic             any_req;
    logic [SRC_W-1:0] winner;

    rr_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .req     (s_axis_tvalid),
        .last    (last_grant),
        .any_req (any_req),
        .winner  (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ARB_IDLE;
            last_grant <= SRC_W'(NUM_SRC - 1);
            grant_idx  <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE && any_req) begin
                grant_idx  <= winner;
                last_grant <= winner;
            end
        end
    end

    // Inside a packet the granted source is wired straight through; nothing is registered.
    always_comb begin
        state_next    = state;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    state_next = ARB_PKT;
                end
            end
            ARB_PKT: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_idx == SRC_W'(i)) begin
                        m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                        m_axis_tvalid    = s_axis_tvalid[i];
                        m_axis_tlast     = s_axis_tlast[i];
                        s_axis_tready[i] = m_axis_tready;
                    end
                end
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign busy = (state == ARB_PKT);

`ifdef AXIS_ARB_TID_EN
    assign m_axis_tid = (state == ARB_PKT) ? grant_idx : '0;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter (4 sources, 32-bit data); optional m_axis_tid covered under AXIS_ARB_TID_EN.
module tb_axis_packet_arbiter;

    localparam int NUM_SRC    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int SRC_W      = 2;

    logic                          clk;
    logic                          rst_n;
    logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_SRC-1:0]            s_axis_tvalid;
    logic [NUM_SRC-1:0]            s_axis_tready;
    logic [NUM_SRC-1:0]            s_axis_tlast;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic [SRC_W-1:0]              grant_idx;
    logic                          busy;
`ifdef AXIS_ARB_TID_EN
    logic [SRC_W-1:0]              m_axis_tid;
`endif

    int errors = 0;
    int checks = 0;

    // Source stimulus state: packet length, current beat, packets sent, packets wanted, data base.
    logic [3:0]  en;
    int          len  [NUM_SRC];
    int          beat [NUM_SRC];
    int          pkt  [NUM_SRC];
    int          npk  [NUM_SRC];
    logic [31:0] base [NUM_SRC];

    axis_packet_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .grant_idx     (grant_idx),
        .busy          (busy)
`ifdef AXIS_ARB_TID_EN
        ,
        .m_axis_tid    (m_axis_tid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive();
        for (int i = 0; i < NUM_SRC; i++) begin
            logic v;
            v = en[i] && (pkt[i] < npk[i]);
            s_axis_tvalid[i] = v;
            s_axis_tlast[i]  = v && (beat[i] == len[i] - 1);
            s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] =
                v ? base[i] + 32'(pkt[i] * len[i] + beat[i]) : 32'h0;
        end
    endtask

    // Called after the negedge check: record handshakes, cross the rising edge, advance sources.
    task automatic adv();
        logic [3:0] hs;
        hs = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hs[i]) begin
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    pkt[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic src_clear();
        en = 4'h0;
        for (int i = 0; i < NUM_SRC; i++) begin
            len[i]  = 1;
            beat[i] = 0;
            pkt[i]  = 0;
            npk[i]  = 0;
            base[i] = 32'h100 * (i + 1);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        src_clear();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        src_clear();
        en = 4'hF;
        for (int i = 0; i < NUM_SRC; i++) npk[i] = 1;
        drive();
        #2;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_mvalid_mlast got=%b%b exp=00", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mdata got=%h exp=00000000", m_axis_tdata);
        end
        checks++;
        if (s_axis_tready !== 4'h0) begin
            errors++;
            $display("FAIL reset_tready got=%b exp=0000", s_axis_tready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant_idx !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant_busy got=%0d/%b exp=0/0", grant_idx, busy);
        end
        do_reset();
    endtask

    task automatic test_two_src();
        int ev [9], el [9], eb [9], eg [9], er [9], ed [9];
        ev = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        el = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
        eb = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
        eg = '{0, 0, 0, 0, 0, 2, 2, 2, 2};
        er = '{0, 1, 1, 1, 0, 4, 4, 4, 0};
        ed = '{0, 'h100, 'h101, 'h102, 0, 'h300, 'h301, 'h302, 0};
        do_reset();
        en = 4'b0101;
        len[0] = 3; npk[0] = 1;
        len[2] = 3; npk[2] = 1;
        drive();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata} !==
                {1'(ev[c]), 1'(el[c]), 1'(eb[c]), 2'(eg[c]), 4'(er[c]), 32'(ed[c])}) begin
                errors++;
                $display("FAIL two_src cyc%0d got v=%b l=%b b=%b g=%0d r=%b d=%h exp v=%0d l=%0d b=%0d g=%0d r=%b d=%h",
                         c, m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata,
                         ev[c], el[c], eb[c], eg[c], 4'(er[c]), 32'(ed[c]));
            end
            adv();
        end
    endtask

    task automatic test_all_src();
        int ph, k, s;
        logic [41:0] exp_v;
        logic [31:0] exp_d;
        do_reset();
        en = 4'hF;
        for (int i = 0; i < NUM_SRC; i++) begin
            len[i] = 2;
            npk[i] = 4;
        end
        drive();
        for (int c = 0; c < 15; c++) begin
            ph = c % 3;
            k  = c / 3;
            s  = k % 4;
            exp_d = (ph != 0) ? base[s] + 32'((k / 4) * 2 + ph - 1) : 32'h0;
            exp_v = {1'(ph != 0), 1'(ph == 2), 1'(ph != 0),
                     2'((ph == 0) ? ((k == 0) ? 0 : (k - 1) % 4) : s),
                     4'((ph != 0) ? (1 << s) : 0), exp_d, 1'b0};
            @(negedge clk);
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata, 1'b0} !== exp_v) begin
                errors++;
                $display("FAIL all_src cyc%0d got=%h exp=%h", c,
                         {m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata, 1'b0}, exp_v);
            end
            adv();
        end
    endtask

    task automatic test_backpressure();
        int rdy [8], ev [8], el [8], eb [8], eg [8], er [8], ed [8];
        rdy = '{1, 1, 0, 0, 1, 1, 1, 1};
        ev  = '{0, 1, 1, 1, 1, 1, 0, 1};
        el  = '{0, 0, 0, 0, 0, 1, 0, 0};
        eb  = '{0, 1, 1, 1, 1, 1, 0, 1};
        eg  = '{0, 1, 1, 1, 1, 1, 1, 3};
        er  = '{0, 2, 0, 0, 2, 2, 0, 8};
        ed  = '{0, 'hA0, 'hA1, 'hA1, 'hA1, 'hA2, 0, 'h400};
        do_reset();
        en = 4'b0010;
        len[1] = 3; npk[1] = 1; base[1] = 32'hA0;
        len[0] = 3; npk[0] = 1;
        len[3] = 3; npk[3] = 1;
        for (int c = 0; c < 8; c++) begin
            m_axis_tready = rdy[c][0];
            if (c == 2) en = en | 4'b1001;
            drive();
            @(negedge clk);
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata} !==
                {1'(ev[c]), 1'(el[c]), 1'(eb[c]), 2'(eg[c]), 4'(er[c]), 32'(ed[c])}) begin
                errors++;
                $display("FAIL backpressure cyc%0d got v=%b l=%b b=%b g=%0d r=%b d=%h exp v=%0d l=%0d b=%0d g=%0d r=%b d=%h",
                         c, m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata,
                         ev[c], el[c], eb[c], eg[c], 4'(er[c]), 32'(ed[c]));
            end
            adv();
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_wrap_single();
        int ev [7], el [7], eb [7], eg [7], er [7], ed [7];
        ev = '{0, 1, 0, 1, 0, 1, 0};
        el = '{0, 1, 0, 1, 0, 1, 0};
        eb = '{0, 1, 0, 1, 0, 1, 0};
        eg = '{0, 2, 2, 3, 3, 0, 0};
        er = '{0, 4, 0, 8, 0, 1, 0};
        ed = '{0, 'h300, 0, 'h400, 0, 'h100, 0};
        do_reset();
        en = 4'b0100;
        npk[2] = 1; npk[3] = 1; npk[0] = 1;
        drive();
        for (int c = 0; c < 7; c++) begin
            if (c == 1) begin
                en = en | 4'b1001;
                drive();
            end
            @(negedge clk);
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata} !==
                {1'(ev[c]), 1'(el[c]), 1'(eb[c]), 2'(eg[c]), 4'(er[c]), 32'(ed[c])}) begin
                errors++;
                $display("FAIL wrap_single cyc%0d got v=%b l=%b b=%b g=%0d r=%b d=%h exp v=%0d l=%0d b=%0d g=%0d r=%b d=%h",
                         c, m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata,
                         ev[c], el[c], eb[c], eg[c], 4'(er[c]), 32'(ed[c]));
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_pkt();
        do_reset();
        en = 4'b0001;
        len[0] = 5; npk[0] = 1;
        drive();
        @(negedge clk);
        adv();
        @(negedge clk);
        adv();
        #1;
        checks++;
        if ({m_axis_tvalid, busy, s_axis_tready, m_axis_tdata} !== {1'b1, 1'b1, 4'b0001, 32'h101}) begin
            errors++;
            $display("FAIL mid_pkt_beat2 got v=%b b=%b r=%b d=%h exp v=1 b=1 r=0001 d=00000101",
                     m_axis_tvalid, busy, s_axis_tready, m_axis_tdata);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata} !== 41'h0) begin
            errors++;
            $display("FAIL mid_pkt_reset got v=%b l=%b b=%b g=%0d r=%b d=%h exp all zero",
                     m_axis_tvalid, m_axis_tlast, busy, grant_idx, s_axis_tready, m_axis_tdata);
        end
        src_clear();
        en = 4'b0011;
        npk[0] = 1; npk[1] = 1;
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got v=%b b=%b exp v=0 b=0", m_axis_tvalid, busy);
        end
        adv();
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, grant_idx, s_axis_tready, m_axis_tdata} !==
            {1'b1, 1'b1, 2'd0, 4'b0001, 32'h100}) begin
            errors++;
            $display("FAIL post_reset_priority got v=%b l=%b g=%0d r=%b d=%h exp v=1 l=1 g=0 r=0001 d=00000100",
                     m_axis_tvalid, m_axis_tlast, grant_idx, s_axis_tready, m_axis_tdata);
        end
        adv();
    endtask

`ifdef AXIS_ARB_TID_EN
    task automatic test_tid();
        int et [4];
        et = '{0, 2, 2, 0};
        do_reset();
        en = 4'b0100;
        len[2] = 2; npk[2] = 1;
        drive();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (m_axis_tid !== 2'(et[c])) begin
                errors++;
                $display("FAIL tid cyc%0d got=%0d exp=%0d", c, m_axis_tid, et[c]);
            end
            adv();
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        m_axis_tready = 1'b1;
        src_clear();
        drive();
        test_reset();
        test_two_src();
        test_all_src();
        test_backpressure();
        test_wrap_single();
        test_reset_mid_pkt();
`ifdef AXIS_ARB_TID_EN
        test_tid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
